// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - shared types, widths and BCD helpers for the ballot tally blocks
package evm_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;
    localparam int BCD_VEC_W  = BCD_W * MAX_DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INCR = 2'd1,
        LOCK = 2'd2
    } tally_state_t;

    // Increment the low n_digits BCD digits of v; MSB of the result is the carry out,
    // which is set only when every one of those digits was 9 (counter already at max).
    function automatic logic [BCD_VEC_W:0] bcd_inc(input logic [BCD_VEC_W-1:0] v,
                                                   input int n_digits);
        logic [BCD_VEC_W-1:0] r;
        logic                 c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n_digits && c) begin
                if (v[i*BCD_W +: BCD_W] == 4'd9) begin
                    r[i*BCD_W +: BCD_W] = 4'd0;
                    c = 1'b1;
                end else begin
                    r[i*BCD_W +: BCD_W] = v[i*BCD_W +: BCD_W] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // True when the low n_digits BCD digits of v are all nines.
    function automatic logic bcd_is_max(input logic [BCD_VEC_W-1:0] v, input int n_digits);
        logic m;
        m = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n_digits && v[i*BCD_W +: BCD_W] != 4'd9) begin
                m = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/vote_tally_bcd_if.sv
// rtl/vote_tally_bcd_if.sv - ballot input / tally display bundle
interface vote_tally_bcd_if #(
    parameter int N_CAND   = 4,
    parameter int N_DIGITS = 3
);
    import evm_pkg::*;

    localparam int SEL_W = $clog2(N_CAND) + 1;

    logic [SEL_W-1:0]          cand_sel;
    logic                      confirm;
    logic                      clear;
    logic [SEL_W-1:0]          show_sel;
    logic [BCD_W*N_DIGITS-1:0] digits;
    logic                      vote_ack;
    logic                      busy;
    logic                      sat;

    modport master (
        output cand_sel, confirm, clear, show_sel,
        input  digits, vote_ack, busy, sat
    );

    modport slave (
        input  cand_sel, confirm, clear, show_sel,
        output digits, vote_ack, busy, sat
    );

endinterface

// File: rtl/evm_btn_sync.sv
// rtl/evm_btn_sync.sv - two-flop synchroniser with rising-edge pulse for push buttons
module evm_btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next-state: shift the raw button through two stages, remember the last synced level
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and edge-history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign btn_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/vote_tally_bcd.sv
// rtl/vote_tally_bcd.sv - per-candidate saturating BCD vote tally with lockout FSM
module vote_tally_bcd
    import evm_pkg::*;
#(
    parameter int N_CAND      = 4,
    parameter int N_DIGITS    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    vote_tally_bcd_if.slave   bus
);

    localparam int SEL_W  = $clog2(N_CAND) + 1;
    localparam int TW     = BCD_W * N_DIGITS;
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    tally_state_t       state_q, state_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [LOCK_W-1:0]  lock_q,  lock_d;
    logic [TW-1:0]      tally_q [N_CAND+1];
    logic [TW-1:0]      tally_d [N_CAND+1];
    logic [TW-1:0]      digits_q, digits_d;
    logic               sat_q,    sat_d;

    logic               confirm_rise;
    logic [SEL_W-1:0]   tgt_idx;
    logic [SEL_W-1:0]   show_idx;
    logic [BCD_VEC_W-1:0] tgt_ext;
    logic [BCD_VEC_W-1:0] show_ext;
    logic [BCD_VEC_W:0]   inc_res;
    logic [TW-1:0]      tgt_next;
    logic               tgt_sat;
    logic               unused_inc_bits;

    evm_btn_sync u_confirm_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (bus.confirm),
        .btn_rise (confirm_rise)
    );

    // Codes at or above N_CAND all map onto the null tally in the last slot
    always_comb begin
        tgt_idx  = (sel_q >= SEL_W'(N_CAND)) ? SEL_W'(N_CAND) : sel_q;
        show_idx = (bus.show_sel >= SEL_W'(N_CAND)) ? SEL_W'(N_CAND) : bus.show_sel;
    end

    // Incremented value of the target tally; a carry out means it is already all nines
    always_comb begin
        tgt_ext          = '0;
        tgt_ext[TW-1:0]  = tally_q[tgt_idx];
        inc_res          = bcd_inc(tgt_ext, N_DIGITS);
        tgt_next         = inc_res[TW-1:0];
        tgt_sat          = inc_res[BCD_VEC_W];
        unused_inc_bits  = ^inc_res[BCD_VEC_W-1:0];
    end

    // FSM next state: capture on a confirm edge, bump once, then hold off further presses
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        lock_d  = lock_q;
        tally_d = tally_q;
        case (state_q)
            IDLE: begin
                if (confirm_rise) begin
                    sel_d   = bus.cand_sel;
                    state_d = INCR;
                end else if (bus.clear) begin
                    for (int i = 0; i <= N_CAND; i++) begin
                        tally_d[i] = '0;
                    end
                end
            end
            INCR: begin
                if (!tgt_sat) begin
                    tally_d[tgt_idx] = tgt_next;
                end
                lock_d  = LOCK_W'(LOCK_CYCLES - 1);
                state_d = LOCK;
            end
            LOCK: begin
                if (lock_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lock_d = lock_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Display path: registered copy of the selected tally and its saturation flag
    always_comb begin
        show_ext         = '0;
        show_ext[TW-1:0] = tally_q[show_idx];
        digits_d         = tally_q[show_idx];
        sat_d            = bcd_is_max(show_ext, N_DIGITS);
    end

    // State, lock counter, tallies and display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            lock_q   <= '0;
            digits_q <= '0;
            sat_q    <= 1'b0;
            for (int i = 0; i <= N_CAND; i++) begin
                tally_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            lock_q   <= lock_d;
            digits_q <= digits_d;
            sat_q    <= sat_d;
            for (int i = 0; i <= N_CAND; i++) begin
                tally_q[i] <= tally_d[i];
            end
        end
    end

    assign bus.digits   = digits_q;
    assign bus.sat      = sat_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.vote_ack = (state_q == INCR) && !tgt_sat;

endmodule

// File: tb/tb_vote_tally_bcd.sv
// tb/tb_vote_tally_bcd.sv - directed self-checking bench for vote_tally_bcd
module tb_vote_tally_bcd;

    logic clk;
    logic rst_n;

    int total;
    int passed;
    int ack_cnt;
    int busy_run;
    int last_busy_len;

    vote_tally_bcd_if #(.N_CAND(4), .N_DIGITS(3)) bus ();

    vote_tally_bcd #(.N_CAND(4), .N_DIGITS(3), .LOCK_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe acks and busy run lengths away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (bus.vote_ack === 1'b1) ack_cnt = ack_cnt + 1;
            if (bus.busy === 1'b1) begin
                busy_run = busy_run + 1;
            end else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run      = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic nibbles_ok(input logic [11:0] d);
        return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9) && (d[11:8] <= 4'd9);
    endfunction

    task automatic cast(input logic [2:0] c);
        int n;
        bus.cand_sel = c;
        bus.confirm  = 1'b1;
        n = 0;
        while (bus.busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("cast_start_timeout", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("cast_end_timeout", 32'(bus.busy), 32'd0);
        bus.confirm = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic show(input logic [2:0] s);
        bus.show_sel = s;
        repeat (2) @(negedge clk);
    endtask

    int ack0;

    initial begin
        total = 0; passed = 0; ack_cnt = 0; busy_run = 0; last_busy_len = 0;
        rst_n = 1'b0;
        bus.cand_sel = '0; bus.confirm = 1'b0; bus.clear = 1'b0; bus.show_sel = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 1: reset state
        check("rst_digits", 32'(bus.digits), 32'h000);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_sat",    32'(bus.sat),    32'd0);
        check("rst_ack",    32'(ack_cnt),    32'd0);

        // 2: held confirm casts exactly one vote, busy lasts 17 cycles
        bus.cand_sel = 3'd2;
        bus.confirm  = 1'b1;
        repeat (100) @(negedge clk);
        bus.confirm = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_one_ack", 32'(ack_cnt), 32'd1);
        check("busy_len",     32'(last_busy_len), 32'd17);
        show(3'd2);
        check("cand2_one", 32'(bus.digits), 32'h001);

        // 3: decimal carries
        for (int i = 0; i < 10; i++) cast(3'd1);
        show(3'd1);
        check("cand1_ten",  32'(bus.digits), 32'h010);
        check("cand1_ten_bcd", 32'(nibbles_ok(bus.digits)), 32'd1);
        for (int i = 0; i < 90; i++) cast(3'd1);
        check("cand1_hundred", 32'(bus.digits), 32'h100);
        check("cand1_hundred_bcd", 32'(nibbles_ok(bus.digits)), 32'd1);

        // 4: saturation at 999
        for (int i = 0; i < 998; i++) cast(3'd0);
        show(3'd0);
        check("cand0_998", 32'(bus.digits), 32'h998);
        check("cand0_998_sat", 32'(bus.sat), 32'd0);
        ack0 = ack_cnt;
        cast(3'd0);
        check("sat_first_ack", 32'(ack_cnt - ack0), 32'd1);
        check("sat_first_digits", 32'(bus.digits), 32'h999);
        check("sat_first_sat", 32'(bus.sat), 32'd1);
        ack0 = ack_cnt;
        cast(3'd0);
        check("sat_second_ack", 32'(ack_cnt - ack0), 32'd0);
        check("sat_second_digits", 32'(bus.digits), 32'h999);
        check("sat_second_sat", 32'(bus.sat), 32'd1);

        // 5: null vote, with a re-press during lock that must be lost
        ack0 = ack_cnt;
        bus.cand_sel = 3'd5;
        bus.confirm  = 1'b1;
        repeat (6) @(negedge clk);
        bus.confirm = 1'b0;
        repeat (4) @(negedge clk);
        check("repress_in_lock", 32'(bus.busy), 32'd1);
        bus.confirm = 1'b1;
        repeat (40) @(negedge clk);
        bus.confirm = 1'b0;
        repeat (5) @(negedge clk);
        check("null_one_ack", 32'(ack_cnt - ack0), 32'd1);
        show(3'd4);
        check("null_tally", 32'(bus.digits), 32'h001);
        show(3'd0); check("null_c0", 32'(bus.digits), 32'h999);
        show(3'd1); check("null_c1", 32'(bus.digits), 32'h100);
        show(3'd2); check("null_c2", 32'(bus.digits), 32'h001);
        show(3'd3); check("null_c3", 32'(bus.digits), 32'h000);

        // 6a: clear during lock is ignored
        bus.cand_sel = 3'd3;
        bus.confirm  = 1'b1;
        repeat (6) @(negedge clk);
        bus.clear = 1'b1;
        repeat (5) @(negedge clk);
        bus.clear = 1'b0;
        repeat (20) @(negedge clk);
        bus.confirm = 1'b0;
        repeat (4) @(negedge clk);
        show(3'd3); check("lock_clear_c3", 32'(bus.digits), 32'h001);
        show(3'd0); check("lock_clear_c0", 32'(bus.digits), 32'h999);

        // 6b: clear in idle zeroes every tally
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        for (int s = 0; s < 5; s++) begin
            show(3'(s));
            check("idle_clear", 32'(bus.digits), 32'h000);
        end
        check("idle_clear_sat", 32'(bus.sat), 32'd0);

        // 6c: reset in the middle of lock
        cast(3'd1);
        show(3'd1);
        check("pre_rst_c1", 32'(bus.digits), 32'h001);
        bus.cand_sel = 3'd1;
        bus.confirm  = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_lock_digits", 32'(bus.digits), 32'h000);
        check("rst_lock_busy",   32'(bus.busy),   32'd0);
        check("rst_lock_ack",    32'(bus.vote_ack), 32'd0);
        check("rst_lock_sat",    32'(bus.sat),    32'd0);
        bus.confirm = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        show(3'd1);
        check("post_rst_c1", 32'(bus.digits), 32'h000);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
